// File: rtl/complex_pkg.sv
// Shared types for the complex datapath and its round-robin front end.
package complex_pkg;

  localparam int CPLX_W = 32;

  typedef enum logic {
    OP_ADD  = 1'b0,
    OP_CONJ = 1'b1
  } cplx_op_e;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/complex_arb_if.sv
// Request/result bundle between the issue ports and complex_arb.
interface complex_arb_if
  import complex_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int ID_WIDTH = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ-1:0]               req_op_i;
  logic [NUM_REQ-1:0][CPLX_W-1:0]   req_a_i;
  logic [NUM_REQ-1:0][CPLX_W-1:0]   req_b_i;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0] req_id_i;

  logic                res_valid_o;
  logic                res_ready_i;
  logic [CPLX_W-1:0]   res_data_o;
  logic [ID_WIDTH-1:0] res_id_o;
  logic [IDX_W-1:0]    res_src_o;

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_id_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_data_o, res_id_o, res_src_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_id_i, res_ready_i,
    output req_ready_o, res_valid_o, res_data_o, res_id_o, res_src_o
  );

endinterface

// File: rtl/complex.sv
// Combinational complex add / conjugate, each 16-bit half wrapping modulo 2^16.
module complex
  import complex_pkg::*;
(
  input  cplx_op_e op_i,
  input  cplx_t    a_i,
  input  cplx_t    b_i,
  output cplx_t    y_o
);

  // Negating 0x8000 wraps back to 0x8000, which is the intended behaviour.
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD: begin
        y_o.re = a_i.re + b_i.re;
        y_o.im = a_i.im + b_i.im;
      end
      OP_CONJ: begin
        y_o.re = a_i.re;
        y_o.im = 16'd0 - a_i.im;
      end
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/complex_rr_arb.sv
// Round-robin picker: scans upward from rr_q and advances past each accepted winner.
module complex_rr_arb #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               can_accept_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [IDX_W-1:0] rr_q;
  logic [IDX_W:0]   sum;
  logic             found;

  // One spare bit on sum lets non-power-of-two NUM_REQ wrap cleanly.
  always_comb begin
    found    = 1'b0;
    winner_o = '0;
    sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!found && valid_i[sum[IDX_W-1:0]]) begin
        found    = 1'b1;
        winner_o = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found && can_accept_i) grant_o[winner_o] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (found && can_accept_i) begin
      rr_q <= (winner_o == IDX_W'(NUM_REQ-1)) ? '0 : winner_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/complex_arb.sv
// Shares one complex datapath between NUM_REQ requesters through a one-entry result buffer.
// Defining COMPLEX_ARB_PERF_EN adds per-requester accept counters and a stall counter.
module complex_arb
  import complex_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int ID_WIDTH = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  complex_arb_if.slave              bus
`ifdef COMPLEX_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0]  perf_accept_o,
  output logic [31:0]               perf_stall_o
`endif
);

  buf_state_e          state_q;
  logic                can_accept;
  logic                accept;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    winner;
  cplx_op_e            dp_op;
  cplx_t               dp_a;
  cplx_t               dp_b;
  cplx_t               dp_y;
  logic [CPLX_W-1:0]   res_data_q;
  logic [ID_WIDTH-1:0] res_id_q;
  logic [IDX_W-1:0]    res_src_q;

  // Gating with rst_ni keeps every ready low while reset is held.
  assign can_accept = rst_ni && ((state_q == BUF_EMPTY) || bus.res_ready_i);

  complex_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .valid_i      (bus.req_valid_i),
    .can_accept_i (can_accept),
    .grant_o      (grant),
    .winner_o     (winner)
  );

  assign accept          = |grant;
  assign bus.req_ready_o = grant;

  assign dp_op = cplx_op_e'(bus.req_op_i[winner]);
  assign dp_a  = cplx_t'(bus.req_a_i[winner]);
  assign dp_b  = cplx_t'(bus.req_b_i[winner]);

  complex u_dp (
    .op_i (dp_op),
    .a_i  (dp_a),
    .b_i  (dp_b),
    .y_o  (dp_y)
  );

  // A drain and a new accept in the same cycle simply overwrite the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BUF_EMPTY;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_src_q  <= '0;
    end else begin
      case (state_q)
        BUF_EMPTY: if (accept) state_q <= BUF_FULL;
        BUF_FULL:  if (!accept && bus.res_ready_i) state_q <= BUF_EMPTY;
        default:   state_q <= BUF_EMPTY;
      endcase
      if (accept) begin
        res_data_q <= dp_y;
        res_id_q   <= bus.req_id_i[winner];
        res_src_q  <= winner;
      end
    end
  end

  assign bus.res_valid_o = (state_q == BUF_FULL);
  assign bus.res_data_o  = res_data_q;
  assign bus.res_id_o    = res_id_q;
  assign bus.res_src_o   = res_src_q;

`ifdef COMPLEX_ARB_PERF_EN
  logic any_valid;

  assign any_valid = |bus.req_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_accept_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) perf_accept_o[i] <= perf_accept_o[i] + 32'd1;
      end
      if (any_valid && !can_accept) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_complex_arb.sv
// Scoreboard bench for complex_arb: a reference model predicts grants and results, a monitor checks them.
module tb_complex_arb;

  localparam int NR = 2;
  localparam int IW = 4;
  localparam int SW = $clog2(NR);

  logic clk = 1'b0;
  logic rst_ni;

  always #5 clk = ~clk;

  complex_arb_if #(.NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

`ifdef COMPLEX_ARB_PERF_EN
  logic [NR-1:0][31:0] perfAccept;
  logic [31:0]         perfStall;
`endif

  complex_arb #(.NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .bus           (bus)
`ifdef COMPLEX_ARB_PERF_EN
    ,
    .perf_accept_o (perfAccept),
    .perf_stall_o  (perfStall)
`endif
  );

  typedef struct {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic [SW-1:0] src;
  } exp_t;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   modelRr     = 0;
  bit   modelFull   = 1'b0;
  int   lastAccept  = -1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers, one 16-bit half at a time.
  function automatic logic [31:0] refResult(input bit op, input logic [31:0] a, input logic [31:0] b);
    int are, aim, bre, bim, re, im;
    are = int'(a[31:16]);
    aim = int'(a[15:0]);
    bre = int'(b[31:16]);
    bim = int'(b[15:0]);
    if (op) begin
      re = are;
      im = (65536 - aim) % 65536;
    end else begin
      re = (are + bre) % 65536;
      im = (aim + bim) % 65536;
    end
    return {re[15:0], im[15:0]};
  endfunction

  task automatic setReq(input int r, input bit op, input logic [31:0] a, input logic [31:0] b,
                        input logic [IW-1:0] id);
    bus.req_op_i[r]    = op;
    bus.req_a_i[r]     = a;
    bus.req_b_i[r]     = b;
    bus.req_id_i[r]    = id;
    bus.req_valid_i[r] = 1'b1;
  endtask

  task automatic modelStep();
    int            w;
    bit            canAcc;
    logic [NR-1:0] expReady;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (modelRr + k) % NR;
      if (w < 0 && bus.req_valid_i[idx]) w = idx;
    end
    canAcc     = !modelFull || bus.res_ready_i;
    expReady   = '0;
    lastAccept = -1;
    if (w >= 0 && canAcc) begin
      expReady[w] = 1'b1;
      lastAccept  = w;
      sb.push_back('{refResult(bus.req_op_i[w], bus.req_a_i[w], bus.req_b_i[w]),
                     bus.req_id_i[w], SW'(w)});
      modelRr = (w + 1) % NR;
    end
    checkOutput("req_ready", 32'(bus.req_ready_o), 32'(expReady));
    modelFull = (lastAccept >= 0) || (modelFull && !bus.res_ready_i);
  endtask

  // One clock: drive res_ready, predict at negedge+1, and retire the accepted request.
  task automatic applyStimulus(input bit resRdy);
    bus.res_ready_i = resRdy;
    @(negedge clk);
    #1;
    modelStep();
    @(posedge clk);
    #1;
    if (lastAccept >= 0) bus.req_valid_i[lastAccept] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (sb.size() > 0) begin
        checkOutput("res_valid", 32'(bus.res_valid_o), 32'd1);
        checkOutput("res_data", bus.res_data_o, sb[0].data);
        checkOutput("res_id", 32'(bus.res_id_o), 32'(sb[0].id));
        checkOutput("res_src", 32'(bus.res_src_o), 32'(sb[0].src));
        if (bus.res_ready_i) void'(sb.pop_front());
      end else begin
        checkOutput("res_valid_idle", 32'(bus.res_valid_o), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a0, b0, a1, b1, expHold;
    rst_ni          = 1'b0;
    bus.req_valid_i = '0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_id_i    = '0;
    bus.res_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    bus.req_valid_i = '1;
    bus.res_ready_i = 1'b1;
    #1;
    checkOutput("reset req_ready", 32'(bus.req_ready_o), 32'd0);
    checkOutput("reset res_valid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("reset res_data", bus.res_data_o, 32'd0);
    checkOutput("reset res_id", 32'(bus.res_id_o), 32'd0);
    checkOutput("reset res_src", 32'(bus.res_src_o), 32'd0);
    bus.req_valid_i = '0;
    bus.res_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

`ifdef COMPLEX_ARB_PERF_EN
    setReq(1, 1'b0, $urandom, $urandom, 4'd1);
    applyStimulus(1'b1);
    setReq(1, 1'b0, $urandom, $urandom, 4'd2);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    setReq(1, 1'b1, $urandom, $urandom, 4'd3);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("perf_accept[1]", perfAccept[1], 32'd3);
    checkOutput("perf_accept[0]", perfAccept[0], 32'd0);
    checkOutput("perf_stall", perfStall, 32'd2);
`endif

    setReq(0, 1'b0, 32'h0001_0002, 32'h0003_FFFF, 4'd5);
    applyStimulus(1'b1);
    checkOutput("add data", bus.res_data_o, 32'h0004_0001);
    checkOutput("add id", 32'(bus.res_id_o), 32'd5);
    checkOutput("add src", 32'(bus.res_src_o), 32'd0);

    setReq(1, 1'b1, 32'h7FFF_8000, $urandom, 4'd9);
    applyStimulus(1'b1);
    checkOutput("conj min", bus.res_data_o, 32'h7FFF_8000);
    setReq(1, 1'b1, 32'h0005_0003, $urandom, 4'd10);
    applyStimulus(1'b1);
    checkOutput("conj neg", bus.res_data_o, 32'h0005_FFFD);
    checkOutput("conj src", 32'(bus.res_src_o), 32'd1);

    setReq(0, 1'b0, $urandom, $urandom, 4'($urandom));
    setReq(1, 1'b0, $urandom, $urandom, 4'($urandom));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      checkOutput("rr src", 32'(bus.res_src_o), 32'(i % 2));
      if (lastAccept >= 0) setReq(lastAccept, 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    #1;
    checkOutput("rr wrap", 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = '0;
    applyStimulus(1'b1);

    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    expHold = refResult(1'b0, a0, b0);
    setReq(0, 1'b0, a0, b0, 4'd3);
    applyStimulus(1'b1);
    setReq(1, 1'b1, a1, b1, 4'd12);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("bp hold data", bus.res_data_o, expHold);
      checkOutput("bp hold id", 32'(bus.res_id_o), 32'd3);
      checkOutput("bp ready", 32'(bus.req_ready_o), 32'd0);
    end
    applyStimulus(1'b1);
    checkOutput("bp next data", bus.res_data_o, refResult(1'b1, a1, b1));
    checkOutput("bp next src", 32'(bus.res_src_o), 32'd1);
    applyStimulus(1'b1);

    setReq(0, 1'b0, $urandom, $urandom, 4'd7);
    applyStimulus(1'b0);
    #2;
    rst_ni          = 1'b0;
    bus.req_valid_i = '1;
    #1;
    checkOutput("midreset res_valid", 32'(bus.res_valid_o), 32'd0);
    checkOutput("midreset res_data", bus.res_data_o, 32'd0);
    checkOutput("midreset req_ready", 32'(bus.req_ready_o), 32'd0);
    sb.delete();
    modelRr   = 0;
    modelFull = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    #1;
    checkOutput("post-reset grant", 32'(bus.req_ready_o), 32'd1);
    applyStimulus(1'b1);

    repeat (400) begin
      for (int r = 0; r < NR; r++) begin
        if (!bus.req_valid_i[r] && ($urandom % 2 == 0)) begin
          setReq(r, 1'($urandom),
                 ($urandom % 4 == 0) ? {16'($urandom), 16'h8000} : $urandom,
                 $urandom, 4'($urandom));
        end
      end
      applyStimulus($urandom % 4 != 0);
    end
    bus.req_valid_i = '0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
